// File: rtl/multi_btn_press_counter_pkg.sv
// rtl/multi_btn_press_counter_pkg.sv - default button timings for a 100 MHz clock
// Holds only the default cycle counts shared by the button counter modules.
package multi_btn_press_counter_pkg;

  localparam int unsigned DEB_10MS     = 1_000_000;
  localparam int unsigned HOLD_500MS   = 50_000_000;
  localparam int unsigned REPEAT_200MS = 20_000_000;

endpackage

// File: rtl/btn_chan_filter.sv
// rtl/btn_chan_filter.sv - one button channel: sync, debounce, press detect, auto-repeat
// Ports:
//   clk_i        system clock
//   rst_i        synchronous reset, active-high
//   btn_i        raw asynchronous button level
//   key_o        debounced button level (registered)
//   press_o      one-cycle pulse per accepted press or repeat (registered)
//   press_next_o value press_o takes at the next edge; lets the counter update on that same edge
module btn_chan_filter
  import multi_btn_press_counter_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = DEB_10MS,
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned HOLD_CYCLES   = HOLD_500MS,
  parameter int unsigned REPEAT_CYCLES = REPEAT_200MS
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic key_o,
  output logic press_o,
  output logic press_next_o
);

  localparam int unsigned     DEB_W    = $clog2(DEB_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             key_q, key_d, key_prev_q;
  logic             press_q;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic             rise;
  logic             rep_fire;

  // Any agreement between s2 and key restarts the stability count.
  always_comb begin
    key_d = key_q;
    deb_d = '0;
    if (s2_q != key_q) begin
      if (deb_q == DEB_LAST) key_d = s2_q;
      else                   deb_d = deb_q + 1'b1;
    end
  end

  assign rise         = key_q & ~key_prev_q;
  assign press_next_o = rise | rep_fire;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      key_q      <= 1'b0;
      key_prev_q <= 1'b0;
      deb_q      <= '0;
      press_q    <= 1'b0;
    end else begin
      s1_q       <= btn_i;
      s2_q       <= s1_q;
      key_q      <= key_d;
      key_prev_q <= key_q;
      deb_q      <= deb_d;
      press_q    <= press_next_o;
    end
  end

  if (REPEAT_EN) begin : g_rep
    localparam int unsigned     TMR_MAX   = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned     TMR_W     = $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             rep_q, rep_d;   // 0: waiting out the hold delay, 1: repeating
    logic             fire;

    // Gating on key_d suppresses a repeat on the very edge the key is released.
    always_comb begin
      tmr_d = '0;
      rep_d = 1'b0;
      fire  = 1'b0;
      if (!rise && key_q && key_d) begin
        rep_d = rep_q;
        if (tmr_q == (rep_q ? REP_LAST : HOLD_LAST)) begin
          fire  = 1'b1;
          rep_d = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        tmr_q <= '0;
        rep_q <= 1'b0;
      end else begin
        tmr_q <= tmr_d;
        rep_q <= rep_d;
      end
    end

    assign rep_fire = fire;
  end else begin : g_norep
    assign rep_fire = 1'b0;
  end

  assign key_o   = key_q;
  assign press_o = press_q;

endmodule

// File: rtl/multi_btn_press_counter.sv
// rtl/multi_btn_press_counter.sv - N-channel debounced push-button press counter
// Ports:
//   clk_i    system clock
//   rst_i    synchronous reset, active-high
//   btn_i    raw asynchronous button inputs, active-high, one per channel
//   clr_i    per-channel synchronous clear of cnt and ovf
//   key_o    debounced button levels
//   press_o  one-cycle pulse per accepted press or repeat
//   cnt_o    per-channel counters, channel i at [i*CNT_W +: CNT_W]
//   ovf_o    sticky per-channel flag, set by a press while the counter is all-ones
module multi_btn_press_counter
  import multi_btn_press_counter_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned DEB_CYCLES    = DEB_10MS,
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned HOLD_CYCLES   = HOLD_500MS,
  parameter int unsigned REPEAT_CYCLES = REPEAT_200MS,
  parameter bit          SATURATE      = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_CH-1:0]         btn_i,
  input  logic [N_CH-1:0]         clr_i,
  output logic [N_CH-1:0]         key_o,
  output logic [N_CH-1:0]         press_o,
  output logic [N_CH*CNT_W-1:0]   cnt_o,
  output logic [N_CH-1:0]         ovf_o
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             press_next;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    btn_chan_filter #(
      .DEB_CYCLES   (DEB_CYCLES),
      .REPEAT_EN    (REPEAT_EN),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_filt (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .btn_i       (btn_i[i]),
      .key_o       (key_o[i]),
      .press_o     (press_o[i]),
      .press_next_o(press_next)
    );

    // Clear takes priority: a press on the same edge is dropped from the count.
    always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clr_i[i]) begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end else if (press_next) begin
        if (&cnt_q) begin
          ovf_d = 1'b1;
          cnt_d = SATURATE ? cnt_q : {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
    end

    assign cnt_o[i*CNT_W +: CNT_W] = cnt_q;
    assign ovf_o[i]                = ovf_q;
  end

endmodule
